fifo_burst_reader: RTL and testbench

//  Read-side master for the fifo block: on a start command, drains exactly burst_len words from the

---
 rtl/fifo_burst_reader_if.sv | 34 +++
 rtl/fifo_burst_reader.sv | 141 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Purpose: bundles the burst-reader command, fifo read-port and output-stream signals.
// Latency: none; this is a wiring bundle only.
// Backpressure: m_ready stalls the stream; fifo_empty stalls the fifo reads.
interface fifo_burst_reader_if #(
    parameter int DATA_SIZE = 8,
    parameter int LEN_W     = 8
);
    // command / status
    logic                 start;
    logic [LEN_W-1:0]     burst_len;
    logic                 busy;
    logic                 done;
    logic [LEN_W-1:0]     words_sent;
    // fifo read port
    logic                 fifo_rd_enable;
    logic [DATA_SIZE-1:0] fifo_data_out;
    logic                 fifo_empty;
    // output stream
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    // master: the burst reader itself
    modport master (
        input  start, burst_len, fifo_data_out, fifo_empty, m_ready,
        output busy, done, words_sent, fifo_rd_enable, m_data, m_valid
    );

    // slave: whatever drives commands, models the fifo and sinks the stream
    modport slave (
        output start, burst_len, fifo_data_out, fifo_empty, m_ready,
        input  busy, done, words_sent, fifo_rd_enable, m_data, m_valid
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Purpose: drains exactly burst_len words from a fifo read port and replays them as a valid/ready stream.
// Latency: first m_valid two cycles after start is sampled, then one word per cycle with m_ready high.
// Backpressure: m_ready low holds m_data/m_valid; a 2-entry buffer absorbs the fifo's 1-cycle read latency.
//
// Ports: clock, reset (synchronous, active-high); bus (master modport) carries start/burst_len/busy/done/
// words_sent, the fifo read port (fifo_rd_enable/fifo_data_out/fifo_empty) and the m_* output stream.
module fifo_burst_reader #(
    parameter int DATA_SIZE = 8,
    parameter int LEN_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    fifo_burst_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_q,      state_d;
    logic [LEN_W-1:0]     remaining_q,  remaining_d;
    logic [LEN_W-1:0]     words_sent_q, words_sent_d;
    logic                 inflight_q,   inflight_d;
    logic [1:0]           occ_q,        occ_d;
    logic [DATA_SIZE-1:0] buf0_q,       buf0_d;     // head entry, drives m_data
    logic [DATA_SIZE-1:0] buf1_q,       buf1_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;

    logic                 pop;
    logic                 issue;
    logic [1:0]           occ_pop;

    // Read issue looks at the buffer as it will be after this cycle's pop, so a
    // full buffer that is draining can still keep the fifo streaming every cycle.
    always_comb begin
        pop     = (occ_q != 2'd0) && bus.m_ready;
        occ_pop = occ_q - 2'(pop);
        issue   = (state_q == S_RUN) && !bus.fifo_empty && (remaining_q != '0)
                  && ((occ_pop + 2'(inflight_q)) < 2'd2);
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        words_sent_d = words_sent_q;
        inflight_d   = issue;
        occ_d        = occ_pop + 2'(inflight_q);
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;

        // Buffer: pop shifts the tail into the head, then the returning read
        // lands in the first free slot after that shift.
        if (pop) begin
            buf0_d       = buf1_q;
            words_sent_d = words_sent_q + LEN_W'(1);
        end
        if (inflight_q) begin
            if (occ_pop == 2'd0) begin
                buf0_d = bus.fifo_data_out;
            end else begin
                buf1_d = bus.fifo_data_out;
            end
        end

        if (issue) begin
            remaining_d = remaining_q - LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    words_sent_d = '0;
                    if (bus.burst_len != '0) begin
                        remaining_d = bus.burst_len;
                        state_d     = S_RUN;
                    end else begin
                        state_d     = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (issue && (remaining_q == LEN_W'(1))) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Nothing outstanding and the buffer drains on this edge.
                if (!inflight_q && (occ_pop == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            words_sent_q <= '0;
            inflight_q   <= 1'b0;
            occ_q        <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            words_sent_q <= words_sent_d;
            inflight_q   <= inflight_d;
            occ_q        <= occ_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // A read issued during a reset cycle would pop a word that the reset then
    // discards, so reset masks the fifo read strobe.
    assign bus.fifo_rd_enable = issue && !reset;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.words_sent     = words_sent_q;
    assign bus.m_valid        = (occ_q != 2'd0);
    assign bus.m_data         = buf0_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Purpose: self-checking bench for fifo_burst_reader with a behavioural registered-read fifo.
// Latency: fifo model returns data the cycle after rd_enable, like the real fifo.
// Backpressure: m_ready driven from per-test patterns.
module tb_fifo_burst_reader;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fifo_burst_reader_if #(.DATA_SIZE(8), .LEN_W(8)) bus ();

    fifo_burst_reader #(.DATA_SIZE(8), .LEN_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- fifo model (registered read) ----------------
    logic [7:0] mem[$];
    logic       wr_en    = 1'b0;
    logic       fifo_clr = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       rd_lat;

    always @(posedge clock) begin
        if (fifo_clr) begin
            mem.delete();
        end else begin
            if (rd_lat && mem.size() != 0) bus.fifo_data_out <= mem.pop_front();
            if (wr_en) mem.push_back(wr_data);
        end
        bus.fifo_empty <= (mem.size() == 0);
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    int         rd_total = 0, done_cnt = 0, rd_empty_viol = 0;
    int         occ_viol = 0, stable_viol = 0, outstanding = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] got[$];

    always @(negedge clock) begin
        rd_lat = bus.fifo_rd_enable;
        if (reset) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (bus.fifo_rd_enable) begin
                rd_total++;
                outstanding++;
                if (bus.fifo_empty) rd_empty_viol++;
            end
            if (bus.m_valid && bus.m_ready) begin
                got.push_back(bus.m_data);
                outstanding--;
            end
            if (outstanding > 2) occ_viol++;
            if (bus.done) done_cnt++;
            if (stall_prev && (!bus.m_valid || bus.m_data != data_prev)) stable_viol++;
            stall_prev = bus.m_valid && !bus.m_ready;
            data_prev  = bus.m_data;
        end
    end

    // ---------------- checking helpers ----------------
    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fifo_load(input int n, input logic [7:0] base, input logic [7:0] step);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i) * step;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic kick(input int len);
        bus.start     = 1'b1;
        bus.burst_len = 8'(len);
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] pat, input string name);
        int n;
        n = 0;
        while (!bus.done && n < 400) begin
            bus.m_ready = pat[n[1:0]];
            tick();
            n++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        bus.m_ready = 1'b1;
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         len;
        int         pre;
        logic [3:0] pat;       // m_ready per cycle, bit index = cycle mod 4
        int         exp_sent;
        int         exp_left;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp3[3];

    initial begin
        int bg, brd, bdn, n, gap, seen;
        logic [7:0] nxt0, nxt1;

        vecs[0] = '{4, 4,  4'b1111, 4, 0};
        vecs[1] = '{6, 8,  4'b1001, 6, 2};   // ready 1,0,0,1,...
        vecs[2] = '{1, 3,  4'b1111, 1, 2};
        vecs[3] = '{5, 5,  4'b0101, 5, 0};
        vecs[4] = '{8, 10, 4'b0011, 8, 2};
        exp3[0] = 8'hA5;
        exp3[1] = 8'h5A;
        exp3[2] = 8'h3C;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.burst_len = 8'd0;
        bus.m_ready   = 1'b0;
        tick();
        tick();
        check("rst_busy",       32'(bus.busy),           32'd0);
        check("rst_done",       32'(bus.done),           32'd0);
        check("rst_rd_enable",  32'(bus.fifo_rd_enable), 32'd0);
        check("rst_m_valid",    32'(bus.m_valid),        32'd0);
        check("rst_m_data",     32'(bus.m_data),         32'd0);
        check("rst_words_sent", 32'(bus.words_sent),     32'd0);
        reset = 1'b0;
        tick();

        // ---- 1: exact latency and back-to-back stream ----
        fifo_load(4, 8'h11, 8'h11);
        bus.m_ready = 1'b1;
        bdn = done_cnt;
        kick(4);
        check("t1_valid_c1", 32'(bus.m_valid), 32'd0);
        check("t1_busy_c1",  32'(bus.busy),    32'd1);
        tick();
        check("t1_valid_c2", 32'(bus.m_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_word%0d", k), 32'({bus.m_valid, bus.m_data}), 32'(256 + (k + 1) * 17));
            tick();
        end
        check("t1_done",       32'(bus.done),       32'd1);
        check("t1_words_sent", 32'(bus.words_sent), 32'd4);
        tick();
        check("t1_done_pulse", 32'(bus.done),       32'd0);
        check("t1_done_count", 32'(done_cnt - bdn), 32'd1);

        // ---- table-driven bursts with back-pressure patterns ----
        for (int i = 0; i < 5; i++) begin
            fifo_load(vecs[i].pre, 8'((i + 1) * 16), 8'd1);
            bg  = got.size();
            brd = rd_total;
            bdn = done_cnt;
            bus.m_ready = vecs[i].pat[0];
            kick(vecs[i].len);
            wait_done(vecs[i].pat, $sformatf("v%0d", i));
            check($sformatf("v%0d_words_sent", i), 32'(bus.words_sent), 32'(vecs[i].exp_sent));
            check($sformatf("v%0d_nwords", i), 32'(got.size() - bg), 32'(vecs[i].exp_sent));
            check($sformatf("v%0d_rd_pulses", i), 32'(rd_total - brd), 32'(vecs[i].exp_sent));
            check($sformatf("v%0d_fifo_left", i), 32'(mem.size()), 32'(vecs[i].exp_left));
            check($sformatf("v%0d_done_count", i), 32'(done_cnt - bdn), 32'd1);
            for (int k = 0; k < vecs[i].exp_sent; k++) begin
                if (bg + k < got.size())
                    check($sformatf("v%0d_word%0d", i, k), 32'(got[bg + k]), 32'((i + 1) * 16 + k));
            end
        end

        // ---- 3: fifo starts empty, words trickle in ----
        fifo_load(0, 8'h00, 8'h00);
        bus.m_ready = 1'b1;
        bg  = got.size();
        bdn = done_cnt;
        kick(3);
        n   = 0;
        gap = 0;
        while (!bus.done && n < 200) begin
            n++;
            wr_en   = (n == 5) || (n == 12) || (n == 13);
            wr_data = (n == 5) ? 8'hA5 : ((n == 12) ? 8'h5A : 8'h3C);
            tick();
            if (!bus.done && !bus.busy) gap++;
        end
        wr_en = 1'b0;
        check("t3_done_seen", 32'(bus.done), 32'd1);
        check("t3_busy_gaps", 32'(gap),      32'd0);
        tick();
        check("t3_done_count", 32'(done_cnt - bdn),  32'd1);
        check("t3_nwords",     32'(got.size() - bg), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (bg + k < got.size())
                check($sformatf("t3_word%0d", k), 32'(got[bg + k]), 32'(exp3[k]));
        end

        // ---- 4: zero-length burst ----
        brd = rd_total;
        bdn = done_cnt;
        bg  = got.size();
        kick(0);
        check("t4_done",    32'(bus.done),    32'd1);
        check("t4_busy",    32'(bus.busy),    32'd0);
        check("t4_m_valid", 32'(bus.m_valid), 32'd0);
        tick();
        check("t4_done_pulse", 32'(bus.done), 32'd0);
        tick();
        check("t4_rd_pulses",  32'(rd_total - brd),  32'd0);
        check("t4_done_count", 32'(done_cnt - bdn),  32'd1);
        check("t4_nwords",     32'(got.size() - bg), 32'd0);
        check("t4_words_sent", 32'(bus.words_sent),  32'd0);

        // ---- 5: reset mid-burst, then a fresh burst ----
        fifo_load(8, 8'h50, 8'd1);
        bus.m_ready = 1'b1;
        bdn = done_cnt;
        kick(5);
        seen = 0;
        n    = 0;
        while (seen < 2 && n < 50) begin
            tick();
            n++;
            if (bus.m_valid && bus.m_ready) seen++;
        end
        check("t5_two_delivered", 32'(seen), 32'd2);
        tick();
        reset = 1'b1;
        tick();
        check("t5_busy",       32'(bus.busy),           32'd0);
        check("t5_done",       32'(bus.done),           32'd0);
        check("t5_rd_enable",  32'(bus.fifo_rd_enable), 32'd0);
        check("t5_m_valid",    32'(bus.m_valid),        32'd0);
        check("t5_m_data",     32'(bus.m_data),         32'd0);
        check("t5_words_sent", 32'(bus.words_sent),     32'd0);
        reset = 1'b0;
        tick();
        check("t5_no_done", 32'(done_cnt - bdn), 32'd0);
        nxt0 = (mem.size() > 0) ? mem[0] : 8'hxx;
        nxt1 = (mem.size() > 1) ? mem[1] : 8'hxx;
        bg   = got.size();
        kick(2);
        wait_done(4'b1111, "t5b");
        check("t5b_nwords",     32'(got.size() - bg), 32'd2);
        check("t5b_words_sent", 32'(bus.words_sent),  32'd2);
        if (got.size() >= bg + 2) begin
            check("t5b_word0", 32'(got[bg]),     32'(nxt0));
            check("t5b_word1", 32'(got[bg + 1]), 32'(nxt1));
        end

        // ---- 6: start while busy is ignored ----
        fifo_load(6, 8'h60, 8'd1);
        bus.m_ready = 1'b1;
        bg  = got.size();
        brd = rd_total;
        bdn = done_cnt;
        kick(4);
        tick();
        bus.start     = 1'b1;
        bus.burst_len = 8'd9;
        tick();
        bus.start     = 1'b0;
        wait_done(4'b1111, "t6");
        repeat (5) tick();
        check("t6_words_sent", 32'(bus.words_sent),  32'd4);
        check("t6_nwords",     32'(got.size() - bg), 32'd4);
        check("t6_rd_pulses",  32'(rd_total - brd),  32'd4);
        check("t6_fifo_left",  32'(mem.size()),      32'd2);
        check("t6_done_count", 32'(done_cnt - bdn),  32'd1);
        check("t6_busy_after", 32'(bus.busy),        32'd0);
        if (got.size() >= bg + 4)
            check("t6_last_word", 32'(got[bg + 3]), 32'h63);

        // ---- invariants gathered across the whole run ----
        check("rd_while_empty",   32'(rd_empty_viol), 32'd0);
        check("occ_plus_inflight", 32'(occ_viol),     32'd0);
        check("stall_stability",  32'(stable_viol),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
